frame_buffer_dbl: RTL

- Parametrised double-buffered frame buffer, successor to the single-bank buffer.
- Two pixel banks: the drawing side writes the back bank while the VGA scan side reads the front bank.
- Banks swap on request, synchronised to frame start, so no tearing.
- A built-in clear engine fills the back bank with one colour.

---
 rtl/fb_pkg.sv | 15 +
 rtl/frame_buffer_dbl_if.sv | 31 +++
 rtl/fb_bank.sv | 46 ++++
 rtl/frame_buffer_dbl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and default resolution constants for the double-buffered frame buffer.
package fb_pkg;

  localparam int FB_H_RES = 640;
  localparam int FB_V_RES = 480;
  localparam int FB_PIX_W = 4;

  typedef logic [FB_PIX_W-1:0] fb_pixel_t;

  typedef enum logic {
    FB_IDLE,
    FB_CLEAR
  } fb_state_e;

endpackage

// File: rtl/frame_buffer_dbl_if.sv
// Drawing/scan-side bus of the double-buffered frame buffer.
interface frame_buffer_dbl_if #(
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 4
);

  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [PIX_W-1:0]  wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  rdata;
  logic              frame_start;
  logic              swap_req;
  logic              swap_pending;
  logic              swap_done;
  logic              clear_req;
  logic [PIX_W-1:0]  clear_color;
  logic              busy;
  logic              front_sel;

  modport master (
    output we, w_addr, wdata, r_addr, frame_start, swap_req, clear_req, clear_color,
    input  rdata, swap_pending, swap_done, busy, front_sel
  );

  modport slave (
    input  we, w_addr, wdata, r_addr, frame_start, swap_req, clear_req, clear_color,
    output rdata, swap_pending, swap_done, busy, front_sel
  );

endinterface

// File: rtl/fb_bank.sv
// One pixel bank: single write port, registered read port returning 0 out of range.
module fb_bank #(
  parameter int DEPTH  = 307200,
  parameter int PIX_W  = 4,
  parameter int ADDR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rdata_q;
  logic             wInRange;
  logic             rInRange;

  assign wInRange = ({1'b0, waddr_i} < DEPTH_W);
  assign rInRange = ({1'b0, raddr_i} < DEPTH_W);

  // Contents are deliberately left unreset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i && wInRange) begin
      mem[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (rInRange) begin
      rdata_q <= mem[raddr_i[IDX_W-1:0]];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame buffer with frame-synchronised bank swap and a back-bank clear engine.
// Define FB_COLOR_KEY_EN to suppress user writes whose pixel equals KEY_COLOR.
module frame_buffer_dbl
  import fb_pkg::*;
#(
  parameter int               H_RES     = FB_H_RES,
  parameter int               V_RES     = FB_V_RES,
  parameter int               PIX_W     = FB_PIX_W,
  parameter int               ADDR_W    = 20,
  parameter logic [PIX_W-1:0] KEY_COLOR = '0
) (
  input logic               Clk,
  input logic               Reset_n,
  frame_buffer_dbl_if.slave bus
);

  localparam int NPIX = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  fb_state_e         state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [PIX_W-1:0]  color_q;
  logic              busy_q;

  logic frontSel_q, frontSel_d;
  logic swapPending_q, swapPending_d;
  logic swapDone_q, swapDone_d;
  logic rdSel_q;

  logic              keyHit;
  logic              clearing;
  logic              userWrite;
  logic              swapExec;
  logic              backWe;
  logic [ADDR_W-1:0] backAddr;
  logic [PIX_W-1:0]  backData;
  logic              we0, we1;
  logic [PIX_W-1:0]  rd0, rd1;

`ifdef FB_COLOR_KEY_EN
  assign keyHit = (bus.wdata == KEY_COLOR);
`else
  assign keyHit = 1'b0 && (bus.wdata == KEY_COLOR);
`endif

  assign clearing  = (state_q == FB_CLEAR);
  assign userWrite = bus.we && !busy_q && !keyHit;
  assign swapExec  = bus.frame_start && swapPending_q && (state_q == FB_IDLE);

  // The back bank is always the one not displayed; a swap cannot happen mid-clear.
  assign backWe   = clearing || userWrite;
  assign backAddr = clearing ? cnt_q   : bus.w_addr;
  assign backData = clearing ? color_q : bus.wdata;
  assign we0      = backWe &&  frontSel_q;
  assign we1      = backWe && !frontSel_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= FB_IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        FB_IDLE: begin
          if (bus.clear_req) begin
            state_q <= FB_CLEAR;
            cnt_q   <= '0;
            color_q <= bus.clear_color;
            busy_q  <= 1'b1;
          end
        end
        FB_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= FB_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= FB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A request arriving on the executing edge re-arms pending for one further swap.
  always_comb begin
    frontSel_d    = frontSel_q ^ swapExec;
    swapPending_d = swapExec ? bus.swap_req : (swapPending_q || bus.swap_req);
    swapDone_d    = swapExec;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frontSel_q    <= 1'b0;
      swapPending_q <= 1'b0;
      swapDone_q    <= 1'b0;
      rdSel_q       <= 1'b0;
    end else begin
      frontSel_q    <= frontSel_d;
      swapPending_q <= swapPending_d;
      swapDone_q    <= swapDone_d;
      rdSel_q       <= frontSel_q;
    end
  end

  fb_bank #(.DEPTH(NPIX), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk_i   (Clk),
    .rst_n_i (Reset_n),
    .we_i    (we0),
    .waddr_i (backAddr),
    .wdata_i (backData),
    .raddr_i (bus.r_addr),
    .rdata_o (rd0)
  );

  fb_bank #(.DEPTH(NPIX), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk_i   (Clk),
    .rst_n_i (Reset_n),
    .we_i    (we1),
    .waddr_i (backAddr),
    .wdata_i (backData),
    .raddr_i (bus.r_addr),
    .rdata_o (rd1)
  );

  assign bus.rdata        = rdSel_q ? rd1 : rd0;
  assign bus.swap_pending = swapPending_q;
  assign bus.swap_done    = swapDone_q;
  assign bus.busy         = busy_q;
  assign bus.front_sel    = frontSel_q;

endmodule
